// File: rtl/tt_sweep_capture_if.sv
// Bundles the handshake and data signals of the truth-table sweep harness.
// The harness (slave side) drives the classifier inputs and reports results.
// The environment (master side) requests sweeps and returns the function output.
//
// Signals:
//   start_i     sweep request, honoured only while the harness is idle
//   expected_i  reference truth table, latched when a sweep is accepted
//   x_o         input vector presented to the classifier
//   f_i         classifier output for the vector currently presented
//   busy_o      sweep (or drain of the capture pipeline) in progress
//   done_o      one-cycle pulse when tt_o / ones_o / match_o are final
//   tt_o        captured truth table, tt_o[k] = f(x = k)
//   ones_o      popcount of tt_o
//   match_o     tt_o equals the latched reference table
`timescale 1ns/1ps

interface tt_sweep_capture_if #(
    parameter int N_IN = 7
);
    localparam int TT_W = 1 << N_IN;

    logic            start_i;
    logic [TT_W-1:0] expected_i;
    logic [N_IN-1:0] x_o;
    logic            f_i;
    logic            busy_o;
    logic            done_o;
    logic [TT_W-1:0] tt_o;
    logic [N_IN:0]   ones_o;
    logic            match_o;

    modport master (
        output start_i,
        output expected_i,
        output f_i,
        input  x_o,
        input  busy_o,
        input  done_o,
        input  tt_o,
        input  ones_o,
        input  match_o
    );

    modport slave (
        input  start_i,
        input  expected_i,
        input  f_i,
        output x_o,
        output busy_o,
        output done_o,
        output tt_o,
        output ones_o,
        output match_o
    );
endinterface

// File: rtl/tt_sweep_capture.sv
// Truth-table sweep harness for an N_IN-input combinational classifier.
// On an accepted start it walks x_o through 0 .. 2^N_IN-1, one value per
// cycle, captures the classifier output for every index into tt_o, keeps a
// running popcount and finally compares the table against a reference.
//
// Ports:
//   clk  system clock, everything on the rising edge
//   rst  synchronous active-high reset, overrides everything including a sweep
//   bus  tt_sweep_capture_if slave modport (start/expected in, x out, f in,
//        busy/done/tt/ones/match out)
//
// Parameters:
//   N_IN  number of classifier inputs (table width 2^N_IN)
//   LAT   cycles from x_o to the matching f_i (0 = purely combinational)
//
// done_o and match_o are registered from the DONE state, so they become
// visible one cycle after DONE, i.e. 2^N_IN+LAT+1 cycles after the start edge.
`timescale 1ns/1ps

module tt_sweep_capture #(
    parameter int N_IN = 7,
    parameter int LAT  = 0
) (
    input  logic               clk,
    input  logic               rst,
    tt_sweep_capture_if.slave  bus
);
    localparam int TT_W = 1 << N_IN;
    localparam int DW   = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'((LAT > 0) ? (LAT - 1) : 0);

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DRAIN,
        DONE
    } state_t;

    state_t          state;
    state_t          next_state;

    logic [N_IN-1:0] drive_cnt;
    logic [DW-1:0]   drain_cnt;
    logic [TT_W-1:0] expected_q;
    logic [TT_W-1:0] tt;
    logic [N_IN:0]   ones;
    logic            match;
    logic            done;

    logic            busy;
    logic [N_IN-1:0] drive_x;
    logic            accept;

    logic            cap_valid;
    logic [N_IN-1:0] cap_idx;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic plus the combinational outputs. The drive counter
    // saturates at the last index, so SWEEP leaves on the all-ones value
    // instead of letting the counter wrap and re-drive index 0.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        drive_x    = '0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start_i) begin
                    accept     = 1'b1;
                    next_state = SWEEP;
                end
            end
            SWEEP: begin
                busy    = 1'b1;
                drive_x = drive_cnt;
                if (&drive_cnt) begin
                    next_state = (LAT > 0) ? DRAIN : DONE;
                end
            end
            DRAIN: begin
                busy    = 1'b1;
                drive_x = drive_cnt;
                if (drain_cnt == DRAIN_LAST) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Capture tag: which index the current f_i belongs to. With LAT=0 it is
    // the index being driven right now; otherwise a valid/index shift line
    // of depth LAT delays the tag to line up with the function's pipeline.
    generate
        if (LAT == 0) begin : g_no_delay
            assign cap_valid = (state == SWEEP);
            assign cap_idx   = drive_cnt;
        end else begin : g_delay
            logic [LAT-1:0]           pipe_valid;
            logic [LAT-1:0][N_IN-1:0] pipe_idx;

            // Tag shift line; only SWEEP cycles inject valid tags so the
            // held index during DRAIN is never captured twice.
            always_ff @(posedge clk) begin
                if (rst) begin
                    pipe_valid <= '0;
                    pipe_idx   <= '0;
                end else begin
                    pipe_valid[0] <= (state == SWEEP);
                    pipe_idx[0]   <= drive_cnt;
                    for (int i = 1; i < LAT; i++) begin
                        pipe_valid[i] <= pipe_valid[i-1];
                        pipe_idx[i]   <= pipe_idx[i-1];
                    end
                end
            end

            assign cap_valid = pipe_valid[LAT-1];
            assign cap_idx   = pipe_idx[LAT-1];
        end
    endgenerate

    // Datapath: counters, table capture, popcount and the final compare.
    // The compare runs in DONE, after the last bit has landed in tt.
    always_ff @(posedge clk) begin
        if (rst) begin
            drive_cnt  <= '0;
            drain_cnt  <= '0;
            expected_q <= '0;
            tt         <= '0;
            ones       <= '0;
            match      <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= (state == DONE);
            if (accept) begin
                expected_q <= bus.expected_i;
                tt         <= '0;
                ones       <= '0;
                match      <= 1'b0;
                drive_cnt  <= '0;
                drain_cnt  <= '0;
            end else begin
                if ((state == SWEEP) && !(&drive_cnt)) begin
                    drive_cnt <= drive_cnt + 1'b1;
                end
                if (state == DRAIN) begin
                    drain_cnt <= drain_cnt + 1'b1;
                end
                if (cap_valid) begin
                    tt[cap_idx] <= bus.f_i;
                    ones        <= ones + (N_IN+1)'(bus.f_i);
                end
                if (state == DONE) begin
                    match <= (tt == expected_q);
                end
            end
        end
    end

    assign bus.x_o     = drive_x;
    assign bus.busy_o  = busy;
    assign bus.done_o  = done;
    assign bus.tt_o    = tt;
    assign bus.ones_o  = ones;
    assign bus.match_o = match;

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Bench for tt_sweep_capture: one LAT=0 instance driven from a lookup-table
// classifier and one LAT=2 instance driven by x6 delayed two cycles.
// Expected tables, popcounts and timings come from a rule-level model.
`timescale 1ns/1ps

module tb_tt_sweep_capture;
    localparam int N_IN = 7;
    localparam int TT_W = 1 << N_IN;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    tt_sweep_capture_if #(.N_IN(N_IN)) bus0 ();
    tt_sweep_capture_if #(.N_IN(N_IN)) bus2 ();

    tt_sweep_capture #(.N_IN(N_IN), .LAT(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    tt_sweep_capture #(.N_IN(N_IN), .LAT(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    // Classifier for the LAT=0 instance: any function as a lookup table.
    logic [TT_W-1:0] f_table;
    assign bus0.f_i = f_table[bus0.x_o];

    // Classifier for the LAT=2 instance: x6 through a two-stage pipeline.
    logic dly1 = 1'b0;
    logic dly2 = 1'b0;
    always @(posedge clk) begin
        dly1 <= bus2.x_o[6];
        dly2 <= dly1;
    end
    assign bus2.f_i = dly2;

    int compare_count = 0;
    int fail_count    = 0;

    int done_at;
    int last_done_at;
    int busy_cycles;
    int done_count;
    bit order_ok;
    logic mid_match;

    // Model helpers.
    function automatic int popcount(input logic [TT_W-1:0] t);
        int n = 0;
        for (int k = 0; k < TT_W; k++) n += int'(t[k]);
        return n;
    endfunction

    // mode 1: f = x0; mode 2: f = x6; mode 3: x6 seen two cycles late
    // by a capture that assumes zero latency (x = 0 before the sweep).
    function automatic logic [TT_W-1:0] rule_table(input int mode);
        logic [TT_W-1:0] t = '0;
        for (int k = 0; k < TT_W; k++) begin
            if (mode == 1) t[k] = (k % 2) == 1;
            else if (mode == 2) t[k] = k >= 64;
            else if (mode == 3) t[k] = (k >= 2) && ((k - 2) >= 64);
        end
        return t;
    endfunction

    function automatic logic [TT_W-1:0] rand_table();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic checkOutput(input string tag, input logic [TT_W-1:0] observed,
                               input logic [TT_W-1:0] expected);
        compare_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Launches one sweep on the selected instance and watches `window`
    // cycles after the start edge (cycle 0 begins at that edge).
    task automatic applyStimulus(input bit use_lat2, input logic [TT_W-1:0] expected,
                                 input int window, input bit hold_start,
                                 input bit stray_pulses);
        int visit = 0;
        logic o_busy, o_done;
        logic [N_IN-1:0] o_x;
        @(negedge clk);
        if (use_lat2) begin bus2.start_i = 1'b1; bus2.expected_i = expected; end
        else begin bus0.start_i = 1'b1; bus0.expected_i = expected; end
        @(posedge clk);
        done_at = -1; last_done_at = -1; busy_cycles = 0; done_count = 0;
        order_ok = 1'b1; mid_match = 1'bx;
        for (int k = 0; k < window; k++) begin
            @(negedge clk);
            if (k == 0) begin
                if (use_lat2) begin bus2.start_i = hold_start; bus2.expected_i = ~expected; end
                else begin bus0.start_i = hold_start; bus0.expected_i = ~expected; end
            end
            if (stray_pulses) bus0.start_i = (k == 10) || (k == 128);
            o_busy = use_lat2 ? bus2.busy_o : bus0.busy_o;
            o_done = use_lat2 ? bus2.done_o : bus0.done_o;
            o_x    = use_lat2 ? bus2.x_o    : bus0.x_o;
            if (k == 60) mid_match = use_lat2 ? bus2.match_o : bus0.match_o;
            if (o_busy) begin
                busy_cycles++;
                if (!use_lat2 && (o_x != N_IN'(visit % TT_W))) order_ok = 1'b0;
                visit++;
            end
            if (o_done) begin
                done_count++;
                if (done_at < 0) done_at = k;
                last_done_at = k;
            end
        end
        bus0.start_i = 1'b0;
        bus2.start_i = 1'b0;
    endtask

    logic [TT_W-1:0] exp_t;
    logic [TT_W-1:0] flip_t;

    initial begin
        rst = 1'b1;
        f_table = '0;
        bus0.start_i = 1'b0; bus0.expected_i = '0;
        bus2.start_i = 1'b0; bus2.expected_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_x", bus0.x_o, 0);
        checkOutput("rst_busy", bus0.busy_o, 0);
        checkOutput("rst_done", bus0.done_o, 0);
        checkOutput("rst_tt", bus0.tt_o, 0);
        checkOutput("rst_ones", bus0.ones_o, 0);
        checkOutput("rst_match", bus0.match_o, 0);
        rst = 1'b0;

        $display("[TB] all-zero function");
        f_table = '0;
        applyStimulus(0, '0, 140, 0, 0);
        checkOutput("zero_done_at", done_at, 129);
        checkOutput("zero_busy_cycles", busy_cycles, 128);
        checkOutput("zero_done_count", done_count, 1);
        checkOutput("zero_tt", bus0.tt_o, 0);
        checkOutput("zero_ones", bus0.ones_o, 0);
        checkOutput("zero_match", bus0.match_o, 1);
        checkOutput("zero_order", order_ok, 1);

        $display("[TB] f = x0");
        f_table = rule_table(1);
        exp_t = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA;
        applyStimulus(0, exp_t, 140, 0, 0);
        checkOutput("x0_mid_match", mid_match, 0);
        checkOutput("x0_tt", bus0.tt_o, exp_t);
        checkOutput("x0_ones", bus0.ones_o, popcount(rule_table(1)));
        checkOutput("x0_match", bus0.match_o, 1);
        flip_t = exp_t ^ 128'h1;
        applyStimulus(0, flip_t, 140, 0, 0);
        checkOutput("x0_flip_match", bus0.match_o, 0);
        checkOutput("x0_flip_ones", bus0.ones_o, 64);

        $display("[TB] class-5 table");
        exp_t = 128'heee8eae8eee8e888eee8e888e8a8e888;
        f_table = exp_t;
        applyStimulus(0, exp_t, 140, 0, 0);
        checkOutput("c5_match", bus0.match_o, 1);
        checkOutput("c5_ones", bus0.ones_o, popcount(exp_t));
        checkOutput("c5_order", order_ok, 1);
        checkOutput("c5_visits", busy_cycles, TT_W);

        $display("[TB] random tables");
        for (int r = 0; r < 4; r++) begin
            logic want_match;
            f_table = rand_table();
            want_match = ($urandom_range(0, 1) == 1);
            flip_t = f_table;
            if (!want_match) flip_t[$urandom_range(0, TT_W-1)] ^= 1'b1;
            applyStimulus(0, flip_t, 140, 0, 0);
            checkOutput("rnd_tt", bus0.tt_o, f_table);
            checkOutput("rnd_ones", bus0.ones_o, popcount(f_table));
            checkOutput("rnd_match", bus0.match_o, want_match);
            checkOutput("rnd_done_at", done_at, 129);
        end

        $display("[TB] LAT=2 instance, f = x6 delayed");
        exp_t = rule_table(2);
        applyStimulus(1, exp_t, 140, 0, 0);
        checkOutput("lat2_done_at", done_at, 131);
        checkOutput("lat2_busy_cycles", busy_cycles, 130);
        checkOutput("lat2_match", bus2.match_o, 1);
        checkOutput("lat2_ones", bus2.ones_o, 64);
        checkOutput("lat2_tt", bus2.tt_o, exp_t);
        compare_count++;
        assert (bus2.tt_o !== rule_table(3)) else begin
            fail_count++;
            $error("[TB] FAIL lat2_misaligned observed=%0h expected_not=%0h", bus2.tt_o, rule_table(3));
        end

        $display("[TB] stray start pulses");
        f_table = rule_table(1);
        applyStimulus(0, rule_table(1), 140, 0, 1);
        checkOutput("stray_done_count", done_count, 1);
        checkOutput("stray_busy_cycles", busy_cycles, 128);
        checkOutput("stray_match", bus0.match_o, 1);

        $display("[TB] start held high");
        applyStimulus(0, rule_table(1), 270, 1, 0);
        checkOutput("held_done_count", done_count, 2);
        checkOutput("held_first_done", done_at, 129);
        checkOutput("held_second_done", last_done_at, 259);
        checkOutput("held_order", order_ok, 1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk);
        @(negedge clk); rst = 1'b0;

        $display("[TB] reset mid-sweep");
        f_table = rand_table();
        @(negedge clk);
        bus0.start_i = 1'b1; bus0.expected_i = f_table;
        @(posedge clk);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            bus0.start_i = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_x", bus0.x_o, 0);
        checkOutput("abort_busy", bus0.busy_o, 0);
        checkOutput("abort_done", bus0.done_o, 0);
        checkOutput("abort_tt", bus0.tt_o, 0);
        checkOutput("abort_ones", bus0.ones_o, 0);
        checkOutput("abort_match", bus0.match_o, 0);
        rst = 1'b0;
        done_count = 0;
        for (int k = 0; k < 140; k++) begin
            @(negedge clk);
            if (bus0.done_o || bus0.busy_o) done_count++;
        end
        checkOutput("abort_quiet", done_count, 0);
        applyStimulus(0, f_table, 140, 0, 0);
        checkOutput("fresh_tt", bus0.tt_o, f_table);
        checkOutput("fresh_match", bus0.match_o, 1);
        checkOutput("fresh_done_at", done_at, 129);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule

// File: doc/tt_sweep_capture.md
Name: tt_sweep_capture

Overview:
- Sequential harness that sits directly upstream and downstream of a 7-input combinational classifier function (x0..x6 -> out).
- On start, drives every input combination 0..2^N_IN-1 into the function and captures each output bit into a truth-table register.
- Counts ones and compares the captured table against an expected signature.
- Result feeds the classification bookkeeping logic.

Parameters:
- N_IN, 7, number of function inputs; table width is 2^N_IN.
- LAT, 0, pipeline latency in cycles from x_o to the corresponding f_i (0 = purely combinational function).

Ports:
- clk  input  1  single system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start_i  input  1  request a sweep; accepted only in IDLE.
- expected_i  input  2^N_IN  expected truth table; sampled on the cycle start is accepted.
- x_o  output  N_IN  input vector to the function; x_o[0] drives x0, up to x_o[N_IN-1] driving x(N_IN-1).
- f_i  input  1  function output.
- busy_o  output  1  sweep in progress.
- done_o  output  1  one-cycle pulse when results are valid.
- tt_o  output  2^N_IN  captured table; tt_o[k] = f(x = k).
- ones_o  output  N_IN+1  popcount of tt_o (range 0..128).
- match_o  output  1  tt_o == sampled expected_i.

Behaviour:
- Reset (rst=1 at an edge) sets:
  - state IDLE
  - x_o=0, busy_o=0, done_o=0, tt_o=0, ones_o=0, match_o=0
  - internal counters and delay line cleared.
- Reset wins over every other event, including mid-sweep. An aborted sweep produces no done_o.
- States are IDLE, SWEEP, DRAIN, DONE.
- IDLE:
  - x_o=0.
  - On start_i=1: latch expected_i, clear tt_o and ones_o, load drive counter = 0, go to SWEEP.
- SWEEP:
  - busy_o=1 and x_o = drive counter. Counter increments every cycle.
  - A valid/index delay line of depth LAT tags each driven index.
  - When the delayed tag is valid for index k: tt_o[k] <= f_i, and ones_o += f_i.
  - After index 2^N_IN-1 is driven, go to DRAIN if LAT>0, else DONE. The counter must not wrap back to 0 and re-drive.
- DRAIN:
  - busy_o=1, x_o holds the last value.
  - Wait LAT cycles until the final tag is captured, then go to DONE.
- DONE:
  - Single cycle: done_o=1, busy_o=0.
  - match_o <= (tt_o == latched expected), computed from the fully written table including the final bit.
  - Return to IDLE.
- Timing:
  - Start accepted at edge E0. Busy spans 2^N_IN+LAT cycles.
  - done_o is high in the cycle beginning at edge E0+2^N_IN+LAT+1.
  - LAT=0, N_IN=7: done_o is high in cycle 129 after E0.
- tt_o, ones_o and match_o hold their values after DONE until the next accepted start or reset.
- match_o reads 0 while busy.
- start_i while busy or in DONE is ignored, with no queuing.
- start_i held high continuously re-triggers on each return to IDLE (one idle cycle between sweeps).
- Changes on expected_i after acceptance have no effect.
- The ones counter cannot overflow: the N_IN+1 bit width holds 2^N_IN exactly.
- Hex convention: tt_o written MSB-first as a hex string; bit 127 corresponds to x=127 (all inputs 1).

Test Plan:
- f_i tied 0, expected_i=0, start pulse
  -> done_o exactly 129 cycles after start edge; tt_o=0, ones_o=0, match_o=1; busy_o high for exactly 128 cycles.
- f_i = x_o[0], expected_i=128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA
  -> tt_o equals expected, ones_o=64, match_o=1. Repeat with expected bit 0 flipped -> match_o=0, ones_o still 64.
- f_i from behavioural model of the class-5 majority network, expected_i=128'heee8eae8eee8e888eee8e888e8a8e888
  -> match_o=1, ones_o equals the model popcount; x_o visits 0..127 in order, each exactly once.
- LAT=2 build, f_i = x_o[6] delayed two cycles, expected upper half ones
  -> done_o 131 cycles after start, match_o=1, ones_o=64. Also check that the LAT=0 capture alignment would fail this test.
- start_i pulsed at cycles 10 and 128 during a sweep
  -> ignored, single done_o. start_i held high -> back-to-back sweeps separated by one IDLE cycle.
- rst asserted at sweep cycle 50
  -> next cycle all outputs 0, state IDLE, no done_o. A fresh start then completes normally with correct tt_o.
